// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the data cache: word type, FSM state encoding, hit-counter address.
// DCACHE_HITCOUNT_EN adds the CNT state used to report the hit counter.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam word_t HITCOUNT_ADDR = 32'h0000_3100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    FETCH = 3'd2,
    FLUSH = 3'd3,
`ifdef DCACHE_HITCOUNT_EN
    CNT   = 3'd4,
`endif
    DONE  = 3'd5
  } dcache_state_t;
endpackage

// File: rtl/dcache_nway_if.sv
// Signal bundle between the datapath/memory environment (master) and dcache_nway (slave).
interface dcache_nway_if;
  import cpu_types_pkg::*;

  logic  dmemREN, dmemWEN, halt, dhit, flushed, dREN, dWEN, dwait;
  word_t dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_lru.sv
// Per-set age-based replacement: touched way becomes age 0, victim is the oldest way.
module dcache_lru #(
  parameter  int unsigned WAYS = 2,
  parameter  int unsigned SETS = 8,
  localparam int unsigned AW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned SW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_touch,
  input  logic [SW-1:0] i_touch_set,
  input  logic [AW-1:0] i_touch_way,
  input  logic [SW-1:0] i_query_set,
  output logic [AW-1:0] o_victim
);
  logic [AW-1:0] r_age [SETS][WAYS];

  // Ages start all-zero; the "<=" rule plus saturation converges to a permutation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          r_age[s][w] <= '0;
    end else if (i_touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (AW'(w) == i_touch_way)
          r_age[i_touch_set][w] <= '0;
        else if (r_age[i_touch_set][w] <= r_age[i_touch_set][i_touch_way] &&
                 r_age[i_touch_set][w] != AW'(WAYS - 1))
          r_age[i_touch_set][w] <= r_age[i_touch_set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    o_victim = '0;
    for (int unsigned w = 1; w < WAYS; w++)
      if (r_age[i_query_set][w] > r_age[i_query_set][o_victim])
        o_victim = AW'(w);
  end
endmodule

// File: rtl/dcache_nway.sv
// N-way write-back data cache with flush-on-halt.
// DCACHE_HITCOUNT_EN: after flush, write a first-lookup hit/miss balance to HITCOUNT_ADDR.
module dcache_nway
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUID = 0,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  input  logic  halt,
  output word_t dmemload,
  output logic  dhit,
  output logic  flushed,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  word_t dload,
  input  logic  dwait
);
  localparam int unsigned OB  = $clog2(WORDS);
  localparam int unsigned OBW = (OB > 0) ? OB : 1;
  localparam int unsigned SW  = $clog2(SETS);
  localparam int unsigned AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TW  = 30 - OB - SW;
  localparam logic [OBW-1:0] LASTW   = OBW'(WORDS - 1);
  localparam logic [AW-1:0]  LASTWAY = AW'(WAYS - 1);
  localparam logic [SW-1:0]  LASTSET = SW'(SETS - 1);
`ifdef DCACHE_HITCOUNT_EN
  localparam dcache_state_t AFTER_FLUSH = CNT;
`else
  localparam dcache_state_t AFTER_FLUSH = DONE;
`endif

  dcache_state_t r_state;
  logic [AW-1:0]  r_way, r_fway;
  logic [OBW-1:0] r_word;
  logic [TW-1:0]  r_tag_q;
  logic [SW-1:0]  r_idx_q, r_fset;
  logic           r_retry;
  logic [SETS-1:0] r_valid [WAYS];
  logic [SETS-1:0] r_dirty [WAYS];
  logic [TW-1:0]  r_tags [WAYS][SETS];
  word_t          r_data [WAYS][SETS][WORDS];
`ifdef DCACHE_HITCOUNT_EN
  word_t          r_hitcnt;
`endif

  logic [TW-1:0]  w_tag;
  logic [SW-1:0]  w_idx;
  logic [OBW-1:0] w_off;
  logic           w_req, w_hit_any, w_inv_any, w_fdirty, w_hit_wr, w_fill, w_last;
  logic [AW-1:0]  w_hit_way, w_inv_way, w_lru_victim, w_victim;

  assign w_tag = dmemaddr[31 -: TW];
  assign w_idx = dmemaddr[2+OB +: SW];
  assign w_off = (WORDS > 1) ? dmemaddr[2 +: OBW] : '0;
  assign w_req = dmemREN | dmemWEN;

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && r_tags[w][w_idx] == w_tag && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_hit_way = AW'(w);
      end
      if (!r_valid[w][w_idx] && !w_inv_any) begin
        w_inv_any = 1'b1;
        w_inv_way = AW'(w);
      end
    end
  end

  assign w_victim = w_inv_any ? w_inv_way : w_lru_victim;
  assign dhit     = (r_state == IDLE) && !halt && w_req && w_hit_any;
  assign dmemload = (dhit && !dmemWEN) ? r_data[w_hit_way][w_idx][w_off] : '0;
  assign w_hit_wr = dhit && dmemWEN;
  assign w_fill   = (r_state == FETCH) && !dwait;
  assign w_last   = (r_word == LASTW);
  assign w_fdirty = r_valid[r_fway][r_fset] && r_dirty[r_fway][r_fset];

  dcache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk         (CLK),
    .rst_n       (nRST),
    .i_touch     (dhit),
    .i_touch_set (w_idx),
    .i_touch_way (w_hit_way),
    .i_query_set (w_idx),
    .o_victim    (w_lru_victim)
  );

  function automatic word_t mk_addr(input logic [TW-1:0] t, input logic [SW-1:0] i,
                                    input logic [OBW-1:0] w);
    word_t a;
    a = {t, {(32-TW){1'b0}}};
    a = a | (word_t'(i) << (2 + OB));
    if (WORDS > 1) a = a | (word_t'(w) << 2);
    return a;
  endfunction

  // Memory-side outputs decode only registered state, never the datapath inputs.
  always_comb begin
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = '0;
    dstore  = '0;
    flushed = 1'b0;
    case (r_state)
      WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(r_tags[r_way][r_idx_q], r_idx_q, r_word);
        dstore = r_data[r_way][r_idx_q][r_word];
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = mk_addr(r_tag_q, r_idx_q, r_word);
      end
      FLUSH: if (w_fdirty) begin
        dWEN   = 1'b1;
        daddr  = mk_addr(r_tags[r_fway][r_fset], r_fset, r_word);
        dstore = r_data[r_fway][r_fset][r_word];
      end
`ifdef DCACHE_HITCOUNT_EN
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCOUNT_ADDR;
        dstore = r_hitcnt;
      end
`endif
      DONE:    flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_hit_wr) r_data[w_hit_way][w_idx][w_off] <= dmemstore;
    if (w_fill) begin
      r_data[r_way][r_idx_q][r_word] <= dload;
      if (w_last) r_tags[r_way][r_idx_q] <= r_tag_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_way   <= '0;
      r_fway  <= '0;
      r_word  <= '0;
      r_tag_q <= '0;
      r_idx_q <= '0;
      r_fset  <= '0;
      r_retry <= 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
`ifdef DCACHE_HITCOUNT_EN
      r_hitcnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (halt) begin
            r_state <= FLUSH;
            r_fset  <= '0;
            r_fway  <= '0;
            r_word  <= '0;
          end else if (w_req) begin
            if (w_hit_any) begin
              if (dmemWEN) r_dirty[w_hit_way][w_idx] <= 1'b1;
              r_retry <= 1'b0;
`ifdef DCACHE_HITCOUNT_EN
              if (!r_retry) r_hitcnt <= r_hitcnt + 1'b1;
`endif
            end else begin
              r_way   <= w_victim;
              r_tag_q <= w_tag;
              r_idx_q <= w_idx;
              r_word  <= '0;
              r_retry <= 1'b1;
`ifdef DCACHE_HITCOUNT_EN
              r_hitcnt <= r_hitcnt - 1'b1;
`endif
              r_state <= (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ? WB : FETCH;
            end
          end
        end
        WB: if (!dwait) begin
          r_word <= w_last ? '0 : r_word + 1'b1;
          if (w_last) r_state <= FETCH;
        end
        FETCH: if (!dwait) begin
          r_word <= w_last ? '0 : r_word + 1'b1;
          if (w_last) begin
            r_valid[r_way][r_idx_q] <= 1'b1;
            r_dirty[r_way][r_idx_q] <= 1'b0;
            r_state                 <= IDLE;
          end
        end
        FLUSH: if (!w_fdirty || (!dwait && w_last)) begin
          // Clean entries advance immediately; dirty ones only after their last word.
          if (w_fdirty) r_dirty[r_fway][r_fset] <= 1'b0;
          r_word <= '0;
          if (r_fway == LASTWAY) begin
            r_fway <= '0;
            if (r_fset == LASTSET) r_state <= AFTER_FLUSH;
            else                   r_fset  <= r_fset + 1'b1;
          end else begin
            r_fway <= r_fway + 1'b1;
          end
        end else if (!dwait) begin
          r_word <= r_word + 1'b1;
        end
`ifdef DCACHE_HITCOUNT_EN
        CNT: if (!dwait) r_state <= DONE;
`endif
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway (WAYS=2, SETS=8, WORDS=2): directed accesses push
// expected memory beats and hits; a negedge monitor pops and compares.
module tb_dcache_nway;
  import cpu_types_pkg::*;

  localparam int KRD  = 0;
  localparam int KWR  = 1;
  localparam int KHIT = 2;

  typedef struct {
    int    kind;
    word_t addr;
    word_t data;
    bit    chk;
    string name;
  } ev_t;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   failures = 0;
  int   n_wr = 0;
  int   exp_hc = 0;
  ev_t  q[$];

  always #5 CLK = ~CLK;

  dcache_nway_if bus();

  function automatic word_t memval(input word_t a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign bus.dload = memval(bus.daddr);

  dcache_nway #(.CPUID(0), .WAYS(2), .SETS(8), .WORDS(2)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dmemREN   (bus.dmemREN),
    .dmemWEN   (bus.dmemWEN),
    .dmemaddr  (bus.dmemaddr),
    .dmemstore (bus.dmemstore),
    .halt      (bus.halt),
    .dmemload  (bus.dmemload),
    .dhit      (bus.dhit),
    .flushed   (bus.flushed),
    .dREN      (bus.dREN),
    .dWEN      (bus.dWEN),
    .daddr     (bus.daddr),
    .dstore    (bus.dstore),
    .dload     (bus.dload),
    .dwait     (bus.dwait)
  );

  task automatic expect_ev(input int k, input word_t a, input word_t d, input bit c, input string n);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.chk = c; e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_fill(input word_t base);
    expect_ev(KRD, base,        32'h0, 1'b0, "fetch_w0");
    expect_ev(KRD, base + 32'h4, 32'h0, 1'b0, "fetch_w1");
  endtask

  task automatic observe(input int k, input word_t a, input word_t d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h with empty scoreboard", k, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.addr != a || (e.chk && e.data != d)) begin
        failures++;
        $display("FAIL %s got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                 e.name, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.dREN && !bus.dwait) observe(KRD, bus.daddr, 32'h0);
      if (bus.dWEN && !bus.dwait) begin
        n_wr++;
        observe(KWR, bus.daddr, bus.dstore);
      end
      if (bus.dhit) observe(KHIT, bus.dmemaddr, bus.dmemload);
    end
  end

  task automatic check(input bit ok, input string n, input word_t got, input word_t want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string n);
    logic [197:0] v;
    v = {bus.dhit, bus.flushed, bus.dREN, bus.dWEN, bus.daddr, bus.dstore, bus.dmemload,
         bus.dmemaddr & 32'h0, bus.dload & 32'h0, bus.dmemstore & 32'h0};
    check(v == '0, n, {bus.dhit, bus.flushed, bus.dREN, bus.dWEN, bus.daddr[27:0]}, 32'h0);
  endtask

  task automatic access(input bit wr, input word_t a, input word_t d, input bit hit_first);
    int n;
    n = 0;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    bus.dmemWEN   = wr;
    bus.dmemREN   = !wr;
    exp_hc += hit_first ? 1 : -1;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.dhit && n < 300);
    if (!bus.dhit) begin
      checks++;
      failures++;
      $display("FAIL access_timeout got=no_dhit want=dhit addr=%h", a);
    end
    @(posedge CLK);
    #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    int    wr_base;
    bit    ok;
    word_t hc;

    bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = '0; bus.dmemstore = '0;
    bus.halt = 0; bus.dwait = 0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_outputs");
    @(posedge CLK); #1 nRST = 1'b1;

    // Cold read, write hit, read back.
    expect_fill(32'h40);
    expect_ev(KHIT, 32'h40, memval(32'h40), 1'b1, "cold_read_hit");
    access(1'b0, 32'h40, 32'h0, 1'b0);
    expect_ev(KHIT, 32'h44, 32'h0, 1'b0, "write_hit");
    access(1'b1, 32'h44, 32'h1111_2222, 1'b1);
    expect_ev(KHIT, 32'h44, 32'h1111_2222, 1'b1, "read_after_write");
    access(1'b0, 32'h44, 32'h0, 1'b1);

    // Fill way1, touch way0, conflicting miss must replace way1 without writeback.
    expect_fill(32'h80);
    expect_ev(KHIT, 32'h80, memval(32'h80), 1'b1, "way1_fill_hit");
    access(1'b0, 32'h80, 32'h0, 1'b0);
    expect_ev(KHIT, 32'h40, memval(32'h40), 1'b1, "way0_rehit");
    access(1'b0, 32'h40, 32'h0, 1'b1);
    expect_fill(32'hC0);
    expect_ev(KHIT, 32'hC0, memval(32'hC0), 1'b1, "lru_replace_hit");
    access(1'b0, 32'hC0, 32'h0, 1'b0);

    // Dirty 0x40 block is now LRU: writeback both words, then fetch.
    expect_ev(KWR, 32'h40, memval(32'h40), 1'b1, "wb_w0");
    expect_ev(KWR, 32'h44, 32'h1111_2222, 1'b1, "wb_w1");
    expect_fill(32'h80);
    expect_ev(KHIT, 32'h80, memval(32'h80), 1'b1, "post_wb_hit");
    access(1'b0, 32'h80, 32'h0, 1'b0);
    expect_ev(KHIT, 32'hC0, memval(32'hC0), 1'b1, "way1_retained");
    access(1'b0, 32'hC0, 32'h0, 1'b1);

    // Memory stall during fetch.
    bus.dwait = 1'b1;
    expect_fill(32'h108);
    expect_ev(KHIT, 32'h108, memval(32'h108), 1'b1, "stall_fill_hit");
    fork
      access(1'b0, 32'h108, 32'h0, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!bus.dREN && n < 20);
        ok = bus.dREN;
        for (int i = 0; i < 5; i++) begin
          if (!(bus.dREN && bus.daddr == 32'h108 && !bus.dhit)) ok = 1'b0;
          if (i < 4) @(negedge CLK);
        end
        check(ok, "stall_stable", bus.daddr, 32'h108);
        @(posedge CLK); #1 bus.dwait = 1'b0;
      end
    join

    // Three dirty blocks then flush.
    expect_fill(32'h10);
    expect_ev(KHIT, 32'h10, 32'h0, 1'b0, "dirty1_hit");
    access(1'b1, 32'h10, 32'hD1D1_0001, 1'b0);
    expect_fill(32'h18);
    expect_ev(KHIT, 32'h18, 32'h0, 1'b0, "dirty2_hit");
    access(1'b1, 32'h18, 32'hD2D2_0002, 1'b0);
    expect_fill(32'h20);
    expect_ev(KHIT, 32'h24, 32'h0, 1'b0, "dirty3_hit");
    access(1'b1, 32'h24, 32'hD3D3_0003, 1'b0);

    expect_ev(KWR, 32'h10, 32'hD1D1_0001, 1'b1, "flush_10");
    expect_ev(KWR, 32'h14, memval(32'h14), 1'b1, "flush_14");
    expect_ev(KWR, 32'h18, 32'hD2D2_0002, 1'b1, "flush_18");
    expect_ev(KWR, 32'h1C, memval(32'h1C), 1'b1, "flush_1c");
    expect_ev(KWR, 32'h20, memval(32'h20), 1'b1, "flush_20");
    expect_ev(KWR, 32'h24, 32'hD3D3_0003, 1'b1, "flush_24");
`ifdef DCACHE_HITCOUNT_EN
    hc = word_t'(exp_hc);
    expect_ev(KWR, HITCOUNT_ADDR, hc, 1'b1, "hitcount");
`else
    hc = '0;
`endif
    wr_base = n_wr;
    @(posedge CLK); #1 bus.halt = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.flushed && n < 300);
    check(bus.flushed, "flush_done", {31'h0, bus.flushed}, 32'h1);
`ifdef DCACHE_HITCOUNT_EN
    check(n_wr - wr_base == 7, "flush_write_count", word_t'(n_wr - wr_base), 32'd7);
`else
    check(n_wr - wr_base == 6, "flush_write_count", word_t'(n_wr - wr_base), 32'd6);
`endif
    check(q.size() == 0, "flush_scoreboard_empty", word_t'(q.size()), 32'h0);

    // Requests in DONE are ignored; flushed holds after halt drops.
    bus.dmemaddr = 32'h40; bus.dmemREN = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!(bus.flushed && !bus.dhit && !bus.dREN && !bus.dWEN)) ok = 1'b0;
      if (i == 4) bus.halt = 1'b0;
    end
    check(ok, "done_hold", {28'h0, bus.flushed, bus.dhit, bus.dREN, bus.dWEN}, 32'h8);
    @(posedge CLK); #1 bus.dmemREN = 1'b0;

    // Reset clears DONE.
    nRST = 1'b0;
    #2 check_reset_outputs("reset_after_done");
    @(posedge CLK); #1 nRST = 1'b1;

    // Reset in the middle of a writeback.
    expect_fill(32'h40);
    expect_ev(KHIT, 32'h40, 32'h0, 1'b0, "pre_wb_write40");
    access(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    expect_fill(32'h80);
    expect_ev(KHIT, 32'h80, 32'h0, 1'b0, "pre_wb_write80");
    access(1'b1, 32'h80, 32'h1234_5678, 1'b0);
    bus.dwait = 1'b1;
    bus.dmemaddr = 32'hC0; bus.dmemREN = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.dWEN && n < 20);
    check(bus.dWEN && bus.daddr == 32'h40, "wb_started", bus.daddr, 32'h40);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("reset_mid_wb");
    @(posedge CLK); #1;
    bus.dmemREN = 1'b0;
    bus.dwait   = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    expect_fill(32'h40);
    expect_ev(KHIT, 32'h40, memval(32'h40), 1'b1, "miss_after_reset");
    access(1'b0, 32'h40, 32'h0, 1'b0);

    repeat (3) @(negedge CLK);
    check(q.size() == 0, "final_scoreboard_empty", word_t'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
